// File: rtl/imem_responder.sv
// imem_responder: single-outstanding instruction fetch responder with fixed latency and a program-load port
//   clk        : clock, all state changes on rising edge
//   reset      : synchronous active-low reset
//   req_*      : fetch request (valid/ready handshake, byte address)
//   rsp_*      : fetch response (valid/ready handshake, instruction word, error flag)
//   load_*     : program-load write port into the instruction memory
//   fetch_cnt  : number of completed response handshakes (wraps)
module imem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  input  logic [31:0]              req_addr,
  output logic                     req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_inst,
  output logic                     rsp_err,
  input  logic                     load_en,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [31:0]              load_data,
  output logic [31:0]              fetch_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] CNT_INIT = 3'(LATENCY > 1 ? LATENCY - 2 : 0);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [31:0] addr_q, rd_addr, rd_inst, rsp_inst_q, fetch_cnt_q;
  logic rd_err, rsp_err_q, enter_resp;
  logic [31:0] mem_q [DEPTH];
  always_comb begin
    // with LATENCY=1 the read happens on the accepting edge, before addr_q holds the address
    rd_addr = state_q == IDLE ? req_addr : addr_q;
    rd_err = |rd_addr[1:0] || |rd_addr[31:AW+2];
    rd_inst = rd_err ? 32'h0000_0013 : mem_q[rd_addr[2+:AW]];
    state_d = state_q;
    cnt_d = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = LATENCY == 1 ? RESP : WAIT;
        enter_resp = LATENCY == 1;
        cnt_d = CNT_INIT;
      end
      WAIT: if (cnt_q == 3'd0) begin
        state_d = RESP;
        enter_resp = 1'b1;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= 3'd0;
      addr_q <= 32'd0;
      rsp_inst_q <= 32'd0;
      rsp_err_q <= 1'b0;
      fetch_cnt_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (state_q == IDLE && req_valid) addr_q <= req_addr;
      if (enter_resp) begin
        rsp_inst_q <= rd_inst;
        rsp_err_q <= rd_err;
      end
      if (state_q == RESP && rsp_ready) fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end
  // memory is not reset; a same-edge write lands after the response register has sampled the old word
  always_ff @(posedge clk) begin
    if (reset && load_en) mem_q[load_addr] <= load_data;
  end
  assign req_ready = reset && state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_inst = rsp_inst_q;
  assign rsp_err = rsp_err_q;
  assign fetch_cnt = fetch_cnt_q;
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: randomized and directed checks of imem_responder against a timestamp-based reference model
module tb_imem_responder;
  localparam int DEPTH = 256;
  localparam int AW = $clog2(DEPTH);
  localparam int LAT = 2;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, load_en;
  logic [31:0] req_addr, rsp_inst, load_data, fetch_cnt;
  logic [AW-1:0] load_addr;
  logic reset1 = 1'b0, req_valid1 = 1'b0, rsp_ready1 = 1'b0, load_en1 = 1'b0;
  logic req_ready1, rsp_valid1, rsp_err1;
  logic [31:0] req_addr1 = 32'd0, load_data1 = 32'd0, rsp_inst1, fetch_cnt1;
  logic [3:0] load_addr1 = 4'd0;
  imem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_err(rsp_err),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .fetch_cnt(fetch_cnt)
  );
  imem_responder #(.DEPTH(16), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset1), .req_valid(req_valid1), .req_addr(req_addr1), .req_ready(req_ready1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_inst(rsp_inst1), .rsp_err(rsp_err1),
    .load_en(load_en1), .load_addr(load_addr1), .load_data(load_data1), .fetch_cnt(fetch_cnt1)
  );
  int errors = 0, checks = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask
  // reference model: a request accepted on edge n is read on edge n+LAT-1 and is
  // visible from the following cycle until the first edge that sees rsp_ready
  logic [31:0] mmem [DEPTH];
  bit pend = 0, chk_en = 0;
  int k = 0, rsp_n = 0;
  logic [31:0] ma = 0, m_inst = 0, m_cnt = 0;
  logic m_err = 0;
  task automatic update();
    if (!reset) begin
      pend = 0;
      m_cnt = 0;
      m_inst = 0;
      m_err = 0;
    end else begin
      if (pend && rsp_n < k && rsp_ready) begin
        pend = 0;
        m_cnt = m_cnt + 1;
      end else if (!pend && req_valid) begin
        pend = 1;
        rsp_n = k + LAT - 1;
        ma = req_addr;
      end
      if (pend && rsp_n == k) begin
        m_err = ma[1:0] != 2'd0 || ma >= 32'(4 * DEPTH);
        m_inst = m_err ? 32'h0000_0013 : mmem[ma[2+:AW]];
      end
      if (load_en) mmem[load_addr] = load_data;
    end
    k++;
  endtask
  task automatic cycle();
    @(negedge clk);
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(reset && !pend));
      check("rsp_valid", 32'(rsp_valid), 32'(pend && rsp_n < k));
      check("rsp_inst", rsp_inst, m_inst);
      check("rsp_err", 32'(rsp_err), 32'(m_err));
      check("fetch_cnt", fetch_cnt, m_cnt);
    end
    @(posedge clk);
    update();
    #1;
  endtask
  task automatic set_idle();
    reset = 1'b1;
    req_valid = 1'b0;
    req_addr = 32'd0;
    rsp_ready = 1'b1;
    load_en = 1'b0;
    load_addr = '0;
    load_data = 32'd0;
  endtask
  task automatic fetch(input logic [31:0] a);
    set_idle();
    req_valid = 1'b1;
    req_addr = a;
    cycle();
    req_valid = 1'b0;
    repeat (LAT + 1) cycle();
  endtask
  initial begin
    set_idle();
    reset = 1'b0;
    cycle();
    chk_en = 1;
    cycle();
    set_idle();
    for (int i = 0; i < DEPTH; i++) begin
      load_en = 1'b1;
      load_addr = AW'(i);
      load_data = i == 0 ? 32'h0010_0093 : i == 1 ? 32'h0010_0073 : $urandom();
      cycle();
    end
    set_idle();
    cycle();
    fetch(32'h0);
    fetch(32'h2);
    fetch(32'h400);
    set_idle();
    req_valid = 1'b1;
    req_addr = 32'h4;
    rsp_ready = 1'b0;
    cycle();
    req_addr = 32'h8;
    repeat (LAT + 5) cycle();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) cycle();
    set_idle();
    req_valid = 1'b1;
    req_addr = 32'h0;
    cycle();
    reset = 1'b0;
    req_valid = 1'b0;
    cycle();
    set_idle();
    cycle();
    fetch(32'h4);
    set_idle();
    req_valid = 1'b1;
    req_addr = 32'h4;
    cycle();
    req_valid = 1'b0;
    load_en = 1'b1;
    load_addr = AW'(1);
    load_data = 32'hDEAD_BEEF;
    repeat (LAT - 1) cycle();
    load_en = 1'b0;
    repeat (2) cycle();
    fetch(32'h4);
    force dut.fetch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.fetch_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    fetch(32'h8);
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 49) != 0;
      req_valid = $urandom_range(0, 1) == 1;
      case ($urandom_range(0, 3))
        0, 1: req_addr = 32'(4 * $urandom_range(0, 15));
        2: req_addr = 32'(4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
        default: req_addr = $urandom_range(0, 1) == 1 ? ($urandom() | 32'h8000_0000) : 32'(4 * DEPTH + 4 * $urandom_range(0, 1000));
      endcase
      rsp_ready = $urandom_range(0, 2) != 0;
      load_en = $urandom_range(0, 3) == 0;
      load_addr = AW'($urandom_range(0, 15));
      load_data = $urandom();
      cycle();
    end
    set_idle();
    chk_en = 0;
    @(posedge clk);
    #1;
    reset1 = 1'b1;
    load_en1 = 1'b1;
    load_addr1 = 4'd3;
    load_data1 = 32'h1234_5678;
    @(posedge clk);
    #1;
    load_en1 = 1'b0;
    req_valid1 = 1'b1;
    req_addr1 = 32'hC;
    @(negedge clk);
    check("l1_req_ready", 32'(req_ready1), 32'd1);
    check("l1_idle_valid", 32'(rsp_valid1), 32'd0);
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
    @(negedge clk);
    check("l1_rsp_valid", 32'(rsp_valid1), 32'd1);
    check("l1_rsp_inst", rsp_inst1, 32'h1234_5678);
    check("l1_rsp_err", 32'(rsp_err1), 32'd0);
    check("l1_busy_ready", 32'(req_ready1), 32'd0);
    rsp_ready1 = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready1 = 1'b0;
    @(negedge clk);
    check("l1_done_valid", 32'(rsp_valid1), 32'd0);
    check("l1_fetch_cnt", fetch_cnt1, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, meaning instruction memory size in 32-bit words (power of two, 4..4096).
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning cycles from request accept to rsp_valid (legal 1..7).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 The block SHALL have port req_valid  input  1  fetch request present.
REQ-006 The block SHALL have port req_addr  input  32  byte address of the instruction to fetch.
REQ-007 The block SHALL have port req_ready  output  1  block can accept a request this cycle.
REQ-008 The block SHALL have port rsp_valid  output  1  response present on rsp_inst/rsp_err.
REQ-009 The block SHALL have port rsp_ready  input  1  initiator accepts the response this cycle.
REQ-010 The block SHALL have port rsp_inst  output  32  fetched instruction word.
REQ-011 The block SHALL have port rsp_err  output  1  request was misaligned or out of range.
REQ-012 The block SHALL have port load_en  input  1  program-load write strobe.
REQ-013 The block SHALL have port load_addr  input  log2(DEPTH)  word index for the load write.
REQ-014 The block SHALL have port load_data  input  32  word written by the load port.
REQ-015 The block SHALL have port fetch_cnt  output  32  count of completed response handshakes.

Function
REQ-016 The block SHALL implement FSM states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 A request SHALL be accepted on an edge where req_valid=1 and req_ready=1; req_addr is captured on that edge.
REQ-018 On accept, the FSM SHALL go to RESP if LATENCY=1; otherwise it SHALL go to WAIT with a down-counter loaded to LATENCY-2.
REQ-019 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the edge where the counter is 0; rsp_valid is thus first high exactly LATENCY cycles after the accepting edge.
REQ-020 rsp_inst and rsp_err SHALL be registered on the edge entering RESP and held stable while rsp_valid=1.
REQ-021 In RESP, rsp_valid SHALL be 1; on an edge with rsp_ready=1 the FSM SHALL return to IDLE and fetch_cnt SHALL increment.
REQ-022 fetch_cnt SHALL wrap from 0xFFFFFFFF to 0.
REQ-023 The block SHALL not pipeline requests; the minimum request-to-request spacing SHALL be LATENCY+1 cycles.
REQ-024 rsp_err SHALL be 1 when req_addr[1:0]!=0 or req_addr>=4*DEPTH; in that case rsp_inst SHALL be 32'h00000013 (nop).
REQ-025 Otherwise, rsp_inst SHALL be mem[req_addr[2+:log2(DEPTH)]] and rsp_err SHALL be 0.
REQ-026 load_en=1 SHALL write load_data to mem[load_addr] on the edge, in any state.
REQ-027 A load write and a RESP-entry read of the same word on the same edge SHALL return the old content (read-before-write).
REQ-028 A load write on any earlier edge SHALL be visible to the read.
REQ-029 Changes on req_valid or req_addr outside IDLE SHALL be ignored.
REQ-030 rsp_ready while not in RESP SHALL be ignored.

Reset
REQ-031 While reset=0 at an edge: state SHALL be IDLE, rsp_valid 0, rsp_inst 0, rsp_err 0, fetch_cnt 0, wait counter 0.
REQ-032 req_ready SHALL be 0 during the reset cycle and SHALL be 1 the cycle after reset is released.
REQ-033 Reset SHALL discard any pending request or response without producing a handshake.
REQ-034 Memory contents SHALL NOT be altered by reset.
REQ-035 load_en SHALL be ignored while reset=0.

Verification
REQ-036 Load mem[0]=0x00100093 and mem[1]=0x00100073; with LATENCY=2, request addr 0x0 with rsp_ready=1 -> rsp_valid high 2 cycles after accept, rsp_inst=0x00100093, rsp_err=0, fetch_cnt=1.
REQ-037 Request addr 0x2, then addr 0x400 with DEPTH=256 -> both responses rsp_err=1, rsp_inst=0x00000013.
REQ-038 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_inst stable; req_ready=0 throughout; single increment of fetch_cnt after rsp_ready=1.
REQ-039 Assert reset=0 while in WAIT -> next cycle rsp_valid=0, fetch_cnt=0; a fresh request after release returns the correct word with full LATENCY.
REQ-040 Load mem[1]=0xDEADBEEF on the same edge the FSM enters RESP for addr 0x4 -> old word returned; a re-fetch returns 0xDEADBEEF.
REQ-041 Force fetch_cnt to 0xFFFFFFFF and complete one handshake -> fetch_cnt=0; with LATENCY=1, rsp_valid is high the cycle after accept.
